// File: rtl/cacheline_mem_arbiter_pkg.sv
// Shared types for the cacheline memory arbiter and the caches around it.
// The arbiter FSM states, the grant identity and the line/address widths
// used by the I-cache, the D-cache and the pmem port all live here.
package arbiter_types;

  localparam int ADDR_W = 32;
  localparam int LINE_W = 256;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_I       = 2'd1,
    ARB_D       = 2'd2,
    ARB_RECOVER = 2'd3
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  // Serving state that corresponds to a given winner.
  function automatic arb_state_t grant_state(input grant_t who);
    arb_state_t st;
    if (who == GNT_D) begin
      st = ARB_D;
    end else begin
      st = ARB_I;
    end
    return st;
  endfunction

endpackage

// File: rtl/cacheline_mem_arbiter_arb_pick.sv
// Winner selection between the I-cache and D-cache miss requests.
// Purely combinational; the FSM decides when the choice is acted on.
// ARB_MODE 0: D-cache wins every tie.
// ARB_MODE 1: on a tie, the side that was not served last wins.
module arb_pick
  import arbiter_types::*;
#(
  parameter int ARB_MODE = 0
) (
  input  logic   i_req,
  input  logic   d_req,
  input  grant_t last_grant,
  output grant_t winner,
  output logic   valid
);

  // Resolve a single winner from the two request lines.
  always_comb begin
    winner = GNT_I;
    valid  = i_req | d_req;
    if (i_req && d_req) begin
      if (ARB_MODE != 32'sd0) begin
        if (last_grant == GNT_I) begin
          winner = GNT_D;
        end else begin
          winner = GNT_I;
        end
      end else begin
        winner = GNT_D;
      end
    end else if (d_req) begin
      winner = GNT_D;
    end else begin
      winner = GNT_I;
    end
  end

endmodule

// File: rtl/cacheline_mem_arbiter.sv
// Shares the single pmem cacheline port between I-cache and D-cache misses.
// One 256-bit line transaction at a time: the winner's address (and, for the
// D side, the writeback line and the op) is latched at grant, pmem is driven
// from those latches, and the pmem response is routed straight back to the
// granted side in the same cycle. A one-cycle recover state after every
// response keeps a requester whose request has not yet dropped from being
// served a second time.
module cacheline_mem_arbiter #(
  parameter int ADDR_W   = arbiter_types::ADDR_W,
  parameter int LINE_W   = arbiter_types::LINE_W,
  parameter int ARB_MODE = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_address,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_address,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  import arbiter_types::arb_state_t;
  import arbiter_types::grant_t;
  import arbiter_types::grant_state;
  import arbiter_types::ARB_IDLE;
  import arbiter_types::ARB_I;
  import arbiter_types::ARB_D;
  import arbiter_types::ARB_RECOVER;
  import arbiter_types::GNT_I;
  import arbiter_types::GNT_D;

  arb_state_t        state_r;
  arb_state_t        state_s;
  grant_t            last_grant_r;
  grant_t            pick_winner_s;
  logic              pick_valid_s;
  logic              i_req_s;
  logic              d_req_s;
  logic              grant_s;
  logic              done_s;
  logic              grant_write_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LINE_W-1:0] wdata_r;
  logic              pmem_read_r;
  logic              pmem_write_r;

  // A D-side request is either a line fill or a writeback.
  assign i_req_s = i_read;
  assign d_req_s = d_read | d_write;

  arb_pick #(
    .ARB_MODE (ARB_MODE)
  ) u_arb_pick (
    .i_req      (i_req_s),
    .d_req      (d_req_s),
    .last_grant (last_grant_r),
    .winner     (pick_winner_s),
    .valid      (pick_valid_s)
  );

  // Write wins when the D-cache raises read and write together.
  assign grant_write_s = (pick_winner_s == GNT_D) && d_write;

  // Next-state decode; also flags the grant and completion cycles.
  always_comb begin
    state_s = state_r;
    grant_s = 1'b0;
    done_s  = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (pick_valid_s) begin
          grant_s = 1'b1;
          state_s = grant_state(pick_winner_s);
        end else begin
          state_s = ARB_IDLE;
        end
      end
      ARB_I, ARB_D: begin
        if (pmem_resp) begin
          done_s  = 1'b1;
          state_s = ARB_RECOVER;
        end else begin
          state_s = state_r;
        end
      end
      ARB_RECOVER: begin
        state_s = ARB_IDLE;
      end
      default: begin
        state_s = ARB_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ARB_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Latch the granted request so later requester activity cannot disturb pmem.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_r       <= '0;
      wdata_r      <= '0;
      last_grant_r <= GNT_I;
    end else if (grant_s) begin
      last_grant_r <= pick_winner_s;
      if (pick_winner_s == GNT_D) begin
        addr_r  <= d_address;
        wdata_r <= d_wdata;
      end else begin
        addr_r  <= i_address;
      end
    end
  end

  // Registered pmem strobes: raised at grant, cleared on the completing response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end else if (grant_s) begin
      pmem_read_r  <= !grant_write_s;
      pmem_write_r <= grant_write_s;
    end else if (done_s) begin
      pmem_read_r  <= 1'b0;
      pmem_write_r <= 1'b0;
    end
  end

  // Route the memory completion only to the side currently being served.
  always_comb begin
    i_resp = 1'b0;
    d_resp = 1'b0;
    if (state_r == ARB_I) begin
      i_resp = pmem_resp;
    end else if (state_r == ARB_D) begin
      d_resp = pmem_resp;
    end else begin
      i_resp = 1'b0;
      d_resp = 1'b0;
    end
  end

  assign pmem_read    = pmem_read_r;
  assign pmem_write   = pmem_write_r;
  assign pmem_address = addr_r;
  assign pmem_wdata   = wdata_r;

  // Read data is a straight pass-through; it is qualified by the resp pulses.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

endmodule
